// File: rtl/usb4_lane_encoder_mp.sv
// usb4_lane_encoder_mp: gathers LANES byte streams into 64b/66b, 128b/132b or passthrough symbols with valid/ready on both sides.
// Optional status outputs sym_cnt/drop_err are built when USB4_ENC_STATUS_EN is defined.
module usb4_lane_encoder_mp #(
  parameter int LANES  = 2,
  parameter int BYTE_W = 8,
  parameter int SYM_W  = 132
) (
  input  logic                    enc_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              gen_speed,
  input  logic [3:0]              d_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*BYTE_W-1:0] lane_tx,
  output logic [LANES*SYM_W-1:0]  lane_tx_enc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    new_sym
`ifdef USB4_ENC_STATUS_EN
  ,
  output logic [15:0]             sym_cnt,
  output logic [0:0]              drop_err
`endif
);
  localparam int PW = 16*BYTE_W;
  typedef enum logic [1:0] {IDLE, GATHER, FULL} state_t;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, len_m1;
  logic [1:0] mode_q, mode_d, m_e, src_m;
  logic data_q, data_d, d_e, src_d;
  logic [LANES*PW-1:0] gbuf_q, gbuf_d, src_buf;
  logic [LANES*SYM_W-1:0] enc_q, enc_d, enc_b;
  logic ov_q, ov_d, ns_q;
  logic acc, last, drain, load;
  function automatic logic [SYM_W-1:0] mk(input logic [PW-1:0] p, input logic [1:0] m, input logic dt);
    mk = '0;
    if (m == 2'd2) mk[8*BYTE_W+1:0] = {dt ? 2'b01 : 2'b10, p[8*BYTE_W-1:0]};
    else if (m == 2'd1) mk[PW+3:0] = {dt ? 4'b0101 : 4'b1010, p};
    else mk[BYTE_W-1:0] = p[BYTE_W-1:0];
  endfunction
  // Mode and header type come from the live inputs only on byte 0 of a block.
  always_comb begin
    m_e = idx_q == 4'd0 ? gen_speed : mode_q;
    d_e = idx_q == 4'd0 ? d_sel == 4'd8 : data_q;
    len_m1 = m_e == 2'd2 ? 4'd7 : m_e == 2'd1 ? 4'd15 : 4'd0;
    in_ready = state_q == GATHER && enable && m_e != 2'd3;
    acc = in_valid && in_ready;
    last = acc && idx_q == len_m1;
    drain = !ov_q || out_ready;
    load = enable && drain && (state_q == FULL || last);
    gbuf_d = gbuf_q;
    for (int l = 0; l < LANES; l++)
      if (acc) gbuf_d[(l*16 + int'(idx_q))*BYTE_W +: BYTE_W] = lane_tx[l*BYTE_W +: BYTE_W];
    src_buf = state_q == FULL ? gbuf_q : gbuf_d;
    src_m = state_q == FULL ? mode_q : m_e;
    src_d = state_q == FULL ? data_q : d_e;
    enc_b = '0;
    for (int l = 0; l < LANES; l++)
      enc_b[l*SYM_W +: SYM_W] = mk(src_buf[l*PW +: PW], src_m, src_d);
    mode_d = acc ? m_e : mode_q;
    data_d = acc ? d_e : data_q;
    idx_d = !enable || last ? 4'd0 : acc ? idx_q + 4'd1 : idx_q;
    enc_d = !enable ? '0 : load ? enc_b : enc_q;
    ov_d = enable && (load || (ov_q && !out_ready));
    state_d = !enable ? IDLE :
              state_q == IDLE ? GATHER :
              state_q == FULL ? (drain ? GATHER : FULL) :
              (last && !drain ? FULL : GATHER);
  end
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      state_q <= GATHER;
      idx_q <= '0;
      mode_q <= '0;
      data_q <= 1'b0;
      gbuf_q <= '0;
      enc_q <= '0;
      ov_q <= 1'b0;
      ns_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      data_q <= data_d;
      gbuf_q <= gbuf_d;
      enc_q <= enc_d;
      ov_q <= ov_d;
      ns_q <= load;
    end
  end
  assign lane_tx_enc = enc_q;
  assign out_valid = ov_q;
  assign new_sym = ns_q;
`ifdef USB4_ENC_STATUS_EN
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      sym_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      if (load) sym_cnt <= sym_cnt + 16'd1;
      if (!enable && (idx_q != 4'd0 || state_q == FULL)) drop_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_usb4_lane_encoder_mp.sv
// tb_usb4_lane_encoder_mp: directed scoreboard bench for usb4_lane_encoder_mp (LANES=2, SYM_W=132).
module tb_usb4_lane_encoder_mp;
  logic enc_clk = 1'b0, rst = 1'b1, enable = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] gen_speed = 2'd2;
  logic [3:0] d_sel = 4'd8;
  logic [15:0] lane_tx = '0;
  logic in_ready, out_valid, new_sym;
  logic [263:0] lane_tx_enc, held;
  logic [263:0] sbq[$];
  int pass_n = 0, total_n = 0;
`ifdef USB4_ENC_STATUS_EN
  logic [15:0] sym_cnt;
  logic [0:0] drop_err;
`endif

  usb4_lane_encoder_mp #(.LANES(2), .BYTE_W(8), .SYM_W(132)) dut (
    .enc_clk(enc_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed), .d_sel(d_sel),
    .in_valid(in_valid), .in_ready(in_ready), .lane_tx(lane_tx), .lane_tx_enc(lane_tx_enc),
    .out_valid(out_valid), .out_ready(out_ready), .new_sym(new_sym)
`ifdef USB4_ENC_STATUS_EN
    , .sym_cnt(sym_cnt), .drop_err(drop_err)
`endif
  );

  always #5 enc_clk = ~enc_clk;

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [263:0] exp_sym(input int mode, input bit dt, input logic [7:0] b0, input logic [7:0] b1);
    logic [263:0] s = '0;
    int n = mode == 2 ? 8 : mode == 1 ? 16 : 1;
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < n; k++) s[l*132 + k*8 +: 8] = 8'((l == 1 ? b1 : b0) + 8'(k));
      if (mode == 2) s[l*132 + 64 +: 2] = dt ? 2'b01 : 2'b10;
      if (mode == 1) s[l*132 + 128 +: 4] = dt ? 4'b0101 : 4'b1010;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge enc_clk);
    #1;
    if (new_sym) begin
      total_n++;
      assert (sbq.size() > 0) pass_n++;
      else $error("FAIL sb_unexpected observed=new_sym expected=no_symbol");
      if (sbq.size() > 0) chk("sym", lane_tx_enc, sbq.pop_front());
    end
  endtask

  task automatic send_block(input int mode, input bit dt, input logic [7:0] b0, input logic [7:0] b1,
                            input int n, input int chg = -1);
    int len = mode == 2 ? 8 : mode == 1 ? 16 : 1;
    bit acc;
    for (int k = 0; k < n; k++) begin
      if (k == chg) d_sel = 4'd8;
      lane_tx = {8'(b1 + 8'(k)), 8'(b0 + 8'(k))};
      in_valid = 1'b1;
      if (k == len - 1) sbq.push_back(exp_sym(mode, dt, b0, b1));
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        #1;
        acc = in_ready;
        tick();
      end
      chk("accept_timeout", acc, 1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_enc", lane_tx_enc, 0);
    chk("rst_new_sym", new_sym, 0);
`ifdef USB4_ENC_STATUS_EN
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_drop_err", drop_err, 0);
`endif
    rst = 1'b0;
    enable = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    // Gen2 data, two lanes
    send_block(2, 1, 8'h00, 8'h10, 8);
    chk("g2_latency_valid", out_valid, 1);
    chk("g2_new_sym", new_sym, 1);
    tick();
    chk("g2_pulse_end", new_sym, 0);
    chk("g2_drained", out_valid, 0);
    // Gen3 ordered set; d_sel change at byte 5 must not alter the header
    gen_speed = 2'd1;
    d_sel = 4'd3;
    send_block(1, 0, 8'hA0, 8'hB0, 16, 5);
    tick();
    // Gen4 passthrough back-to-back
    gen_speed = 2'd0;
    d_sel = 4'd8;
    send_block(0, 1, 8'h5A, 8'h11, 1);
    chk("g4_valid_1", out_valid, 1);
    send_block(0, 1, 8'hC3, 8'h22, 1);
    chk("g4_valid_2", out_valid, 1);
    tick();
    // Gen2 backpressure: second block fills the gather buffer
    gen_speed = 2'd2;
    out_ready = 1'b0;
    held = exp_sym(2, 1, 8'h30, 8'h60);
    send_block(2, 1, 8'h30, 8'h60, 8);
    send_block(2, 1, 8'h38, 8'h68, 8);
    chk("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_hold_sym", lane_tx_enc, held);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_second_valid", out_valid, 1);
    tick();
    chk("bp_done", out_valid, 0);
    // Flush after 3 Gen3 bytes; a byte offered during the flush cycle is ignored
    gen_speed = 2'd1;
    send_block(1, 1, 8'hE0, 8'hF0, 3);
    enable = 1'b0;
    in_valid = 1'b1;
    lane_tx = 16'hFFFF;
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_enc", lane_tx_enc, 0);
    chk("flush_in_ready", in_ready, 0);
`ifdef USB4_ENC_STATUS_EN
    chk("flush_drop_err", drop_err, 1);
`endif
    in_valid = 1'b0;
    enable = 1'b1;
    tick();
    send_block(1, 1, 8'h40, 8'h50, 16);
    tick();
    // Reset mid-block with a symbol held
    gen_speed = 2'd2;
    out_ready = 1'b0;
    send_block(2, 1, 8'h70, 8'h80, 8);
    send_block(2, 1, 8'h00, 8'h00, 3);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_enc", lane_tx_enc, 0);
    chk("mid_rst_new_sym", new_sym, 0);
`ifdef USB4_ENC_STATUS_EN
    chk("mid_rst_sym_cnt", sym_cnt, 0);
`endif
    rst = 1'b0;
    out_ready = 1'b1;
    send_block(2, 1, 8'h90, 8'hA0, 8);
    tick();
    // Reserved speed accepts nothing
    gen_speed = 2'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("g_rsvd_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/usb4_lane_encoder_mp.md
Name: usb4_lane_encoder_mp

Overview:
- Parametrised successor to the two-lane logical-layer byte encoder.
- Gathers per-lane transmit bytes into 64b/66b (Gen2) or 128b/132b (Gen3) symbols, or passes bytes through (Gen4), for LANES lanes.
- Adds valid/ready handshakes toward the transport source and the serializer, with one-symbol buffering.
- Sits between the lane adapter / ordered-set generator and the per-lane serializers.

Parameters:
- LANES, 2, number of lanes gathered in lock-step (1..4).
- BYTE_W, 8, byte width; fixed at 8, kept for a lint-visible width.
- SYM_W, 132, per-lane output symbol width; must be >= 4+16*BYTE_W.

Ports:
- enc_clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  0 = flush: discard the partial block and clear outputs.
- gen_speed  in  2  0 = Gen4 byte passthrough, 1 = Gen3 128b/132b, 2 = Gen2 64b/66b, 3 = reserved.
- d_sel  in  4  source select; 8 = transport data, anything else = ordered set.
- in_valid  in  1  lane bytes valid.
- in_ready  out  1  encoder accepts bytes this cycle.
- lane_tx  in  LANES*8  byte for lane n at [n*8+:8].
- lane_tx_enc  out  LANES*SYM_W  symbol for lane n at [n*SYM_W+:SYM_W].
- out_valid  out  1  lane_tx_enc holds a symbol.
- out_ready  in  1  serializer accepts the symbol.
- new_sym  out  1  one-cycle pulse when a new symbol loads into the output register.

Behaviour:
- Reset: all outputs are 0, except in_ready, which is 1 after reset is released.
  - Internal state on reset: gather buffer, byte index, latched d_sel and mode all cleared.
- Reset has priority over everything; a block in progress is dropped.
- Byte accept happens when in_valid && in_ready.
- Block length: Gen2 = 8 bytes, Gen3 = 16 bytes, Gen4 = 1 byte.
- Byte k of a block goes to bits [k*8+:8] of that lane's payload.
- d_sel and gen_speed are latched on byte 0 of each block; later changes within the block are ignored.
- Header sits directly above the payload; unused upper bits are 0.
  - Gen2: bits [65:64] = 2'b01 for data, 2'b10 for ordered set.
  - Gen3: bits [131:128] = 4'b0101 for data, 4'b1010 for ordered set.
  - Gen4: bits [7:0] = byte, header none.
- gen_speed=3: in_ready=0; nothing is accepted.
- State machine:
  - IDLE: enable=0. in_ready=0, out_valid=0, index=0. Go to GATHER when enable=1.
  - GATHER: accept bytes and increment the index. On the last byte of a block, go to FULL, or go straight to the output if the output register is free or draining this cycle.
  - FULL: a completed block waits for the output register; in_ready=0.
- Output register:
  - Loads when the output is empty, or when out_valid && out_ready in the same cycle.
  - Load sets out_valid=1 and pulses new_sym=1 for 1 cycle.
  - Without a refill, out_valid clears after the out_ready handshake.
- Latency: last byte accepted at cycle t gives out_valid=1 at t+1.
- Back-to-back: with out_ready held at 1 there are no bubbles; in_ready stays 1 continuously.
- Backpressure: while out_valid && !out_ready, a second block may complete into the gather buffer (FULL). Only then does in_ready drop; nothing is overwritten.
- enable drops mid-block:
  - Next cycle: partial block and FULL block discarded, out_valid=0, lane_tx_enc=0, state IDLE.
  - In the same cycle, enable=0 takes precedence over any byte accept.
- gen_speed changes mid-block: ignored until the block completes; the new mode applies from the next byte 0.
- Index wrap: after the last byte the index returns to 0; no modulo-16 aliasing in Gen2.
- All lanes share one index and one header type.

Optional Feature:
- Macro USB4_ENC_STATUS_EN.
- Defined: adds two outputs.
  - sym_cnt [15:0]: increments on each new_sym, wraps at 0xFFFF -> 0, cleared by rst.
  - drop_err [0:0]: sticky; set when enable falls with a non-empty gather or FULL buffer, cleared only by rst.
- Undefined: neither port exists; no added logic.

Test Plan:
- Gen2, LANES=2, d_sel=8, lane0 bytes 0x00..0x07, lane1 bytes 0x10..0x17, out_ready=1 -> one cycle after the 8th byte: lane0 sym = {2'b01,64'h0706050403020100}, lane1 sym = {2'b01,64'h1716151413121110}, new_sym single pulse.
- Gen3, d_sel=3, 16 bytes 0xA0..0xAF on lane0 -> lane0 sym = {4'b1010,128'hAFAE...A1A0}; d_sel changed to 8 at byte 5 has no effect on the header.
- Gen4, bytes 0x5A then 0xC3 back-to-back -> out_valid two consecutive cycles, lane_tx_enc[7:0] = 0x5A then 0xC3, upper bits 0.
- Backpressure in Gen2: out_ready=0 for 20 cycles with continuous in_valid:
  - first symbol held stable;
  - second block completes, then in_ready=0;
  - out_ready=1 -> both symbols delivered in order, no bytes lost.
- enable=0 after 3 Gen3 bytes -> next cycle out_valid=0, lane_tx_enc=0.
  - Re-enable and send 16 new bytes -> symbol contains only the new bytes.
  - With USB4_ENC_STATUS_EN: drop_err=1.
- rst=1 asserted mid-block with out_valid=1 -> next edge all outputs 0, sym_cnt=0. gen_speed=3 -> in_ready=0 indefinitely.
